// File: rtl/dev_csr_initiator.sv
// Manager-side CSR initiator: host commands go out through a one-entry request
// register; read data returns in order through a one-entry response buffer.
module dev_csr_initiator #(
    parameter int RegDataWidth   = 32,
    parameter int RegAddrWidth   = 3,
    parameter int MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [RegAddrWidth-1:0] cmd_addr_i,
    input  logic [RegDataWidth-1:0] cmd_wr_data_i,
    input  logic                    cmd_wr_en_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    output logic [RegDataWidth-1:0] rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [RegAddrWidth-1:0] csr_addr_o,
    output logic [RegDataWidth-1:0] csr_wr_data_o,
    output logic                    csr_wr_en_o,
    output logic                    csr_req_valid_o,
    input  logic                    csr_req_ready_i,
    input  logic [RegDataWidth-1:0] csr_rd_data_i,
    input  logic                    csr_rsp_valid_i,
    output logic                    csr_rsp_ready_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic                    req_v_reg, req_v_next;
    logic [RegAddrWidth-1:0] req_addr_reg, req_addr_next;
    logic [RegDataWidth-1:0] req_wr_data_reg, req_wr_data_next;
    logic                    req_wr_en_reg, req_wr_en_next;
    logic [CntW-1:0]         rd_cnt_reg, rd_cnt_next;
    logic [CntW-1:0]         infl_reg, infl_next;
    logic                    rd_valid_reg, rd_valid_next;
    logic [RegDataWidth-1:0] rd_data_reg, rd_data_next;
    logic                    err_reg, err_next;

    logic cmd_ready, cmd_hs, cmd_rd, req_hs, rd_issue;
    logic rsp_ready, rsp_hs, rsp_expected, host_hs;

    // Credit check uses the registered count only, so a freed credit is seen next cycle.
    assign cmd_ready    = (!req_v_reg || csr_req_ready_i) && (cmd_wr_en_i || (rd_cnt_reg < MaxCnt));
    assign cmd_hs       = cmd_valid_i && cmd_ready;
    assign cmd_rd       = cmd_hs && !cmd_wr_en_i;
    assign req_hs       = req_v_reg && csr_req_ready_i;
    assign rd_issue     = req_hs && !req_wr_en_reg;
    assign rsp_ready    = !rd_valid_reg || rd_ready_i;
    assign rsp_hs       = csr_rsp_valid_i && rsp_ready;
    assign rsp_expected = rsp_hs && ((infl_reg != '0) || rd_issue);
    assign host_hs      = rd_valid_reg && rd_ready_i;

    always_comb begin
        req_v_next       = req_v_reg;
        req_addr_next    = req_addr_reg;
        req_wr_data_next = req_wr_data_reg;
        req_wr_en_next   = req_wr_en_reg;
        rd_cnt_next      = rd_cnt_reg;
        infl_next        = infl_reg;
        rd_valid_next    = rd_valid_reg;
        rd_data_next     = rd_data_reg;
        err_next         = err_reg;

        if (cmd_hs) begin
            req_v_next       = 1'b1;
            req_addr_next    = cmd_addr_i;
            req_wr_data_next = cmd_wr_data_i;
            req_wr_en_next   = cmd_wr_en_i;
        end else if (req_hs) begin
            req_v_next = 1'b0;
        end

        case ({cmd_rd, host_hs})
            2'b10:   rd_cnt_next = rd_cnt_reg + CntW'(1);
            2'b01:   rd_cnt_next = rd_cnt_reg - CntW'(1);
            default: rd_cnt_next = rd_cnt_reg;
        endcase

        case ({rd_issue, rsp_expected})
            2'b10:   infl_next = infl_reg + CntW'(1);
            2'b01:   infl_next = infl_reg - CntW'(1);
            default: infl_next = infl_reg;
        endcase

        // A new capture wins over the host draining the buffer in the same cycle.
        if (rsp_expected) begin
            rd_valid_next = 1'b1;
            rd_data_next  = csr_rd_data_i;
        end else if (host_hs) begin
            rd_valid_next = 1'b0;
        end

        if (rsp_hs && !rsp_expected) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_v_reg       <= 1'b0;
            req_addr_reg    <= '0;
            req_wr_data_reg <= '0;
            req_wr_en_reg   <= 1'b0;
            rd_cnt_reg      <= '0;
            infl_reg        <= '0;
            rd_valid_reg    <= 1'b0;
            rd_data_reg     <= '0;
            err_reg         <= 1'b0;
        end else begin
            req_v_reg       <= req_v_next;
            req_addr_reg    <= req_addr_next;
            req_wr_data_reg <= req_wr_data_next;
            req_wr_en_reg   <= req_wr_en_next;
            rd_cnt_reg      <= rd_cnt_next;
            infl_reg        <= infl_next;
            rd_valid_reg    <= rd_valid_next;
            rd_data_reg     <= rd_data_next;
            err_reg         <= err_next;
        end
    end

    assign cmd_ready_o     = cmd_ready;
    assign csr_rsp_ready_o = rsp_ready;
    assign csr_req_valid_o = req_v_reg;
    assign csr_addr_o      = req_addr_reg;
    assign csr_wr_data_o   = req_wr_data_reg;
    assign csr_wr_en_o     = req_wr_en_reg;
    assign rd_valid_o      = rd_valid_reg;
    assign rd_data_o       = rd_data_reg;
    assign err_o           = err_reg;
    assign busy_o          = req_v_reg || (infl_reg != '0) || rd_valid_reg;

endmodule

// File: doc/dev_csr_initiator.md
# dev_csr_initiator

Manager-side driver for the CSR request/response interface that dev accelerator wrappers expose as a responder. It accepts CSR commands from a host port (test sequencer or control core shim), issues them on the CSR request channel with valid/ready flow control, and returns read data in order to the host through a registered response buffer. A credit counter bounds outstanding reads, and an in-flight counter flags protocol errors.

## Interface
Parameters:
- RegDataWidth, 32, CSR data width
- RegAddrWidth, 3, CSR address width
- MaxOutstanding, 2, maximum reads accepted from host and not yet delivered back (1..15)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- cmd_addr_i  in  RegAddrWidth  host command address
- cmd_wr_data_i  in  RegDataWidth  host write data
- cmd_wr_en_i  in  1  1 = write, 0 = read
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  command accepted when valid && ready
- rd_data_o  out  RegDataWidth  read data to host
- rd_valid_o  out  1  read data valid
- rd_ready_i  in  1  host accepts read data
- csr_addr_o  out  RegAddrWidth  CSR request address
- csr_wr_data_o  out  RegDataWidth  CSR request write data
- csr_wr_en_o  out  1  CSR request write enable
- csr_req_valid_o  out  1  CSR request valid
- csr_req_ready_i  in  1  responder accepts request
- csr_rd_data_i  in  RegDataWidth  CSR read response data
- csr_rsp_valid_i  in  1  CSR response valid
- csr_rsp_ready_o  out  1  initiator accepts response
- busy_o  out  1  request pending, read in flight, or read data buffered
- err_o  out  1  sticky: response received with nothing in flight

## Operation
- Request register (one entry): req_q holds {addr, wr_data, wr_en}, valid flag req_v.
  - Load on cmd handshake; clear on CSR request handshake without new load.
  - cmd_ready_o = (!req_v || csr_req_ready_i) && (cmd_wr_en_i || rd_cnt < MaxOutstanding).
  - Load and drain in the same cycle allowed (full throughput, one command per cycle).
  - csr_* request outputs driven from req_q; stable while csr_req_valid_o && !csr_req_ready_i.
- Credit counter rd_cnt (width $clog2(MaxOutstanding+1)): +1 on read cmd handshake, −1 on host read handshake (rd_valid_o && rd_ready_i); both same cycle → unchanged. Never exceeds MaxOutstanding, never below 0.
- In-flight counter infl: +1 on CSR request handshake with csr_wr_en_o = 0, −1 on CSR response handshake; both same cycle → unchanged.
- Writes produce no response; they never touch rd_cnt or infl.
- Response buffer (one entry): csr_rsp_ready_o = !rd_valid_o || rd_ready_i. Response handshake with infl > 0 (or incrementing same cycle) → capture csr_rd_data_i, set rd_valid_o.
- Unexpected response: csr_rsp_valid_i with infl = 0 and no read issuing this cycle → handshake completes (ready per rule above), data dropped, infl unchanged, err_o set; err_o clears only on reset.
- Ordering: responses delivered to host in CSR issue order; no reordering, no ID.
- busy_o = req_v || infl != 0 || rd_valid_o.

## Timing
- Reset (rst_i high at clock edge): req_v = 0, rd_valid_o = 0, rd_cnt = 0, infl = 0, err_o = 0, req_q and rd_data_o = 0. After reset cmd_ready_o = 1, csr_req_valid_o = 0, csr_rsp_ready_o = 1, busy_o = 0.
- Reset mid-operation discards pending request, buffered data, and counters; responses arriving later raise err_o.
- Cmd handshake at cycle N → csr_req_valid_o high at N+1.
- Response handshake at cycle M → rd_valid_o high at M+1; rd_data_o stable until host handshake.
- rd_cnt = MaxOutstanding: read commands stalled (cmd_ready_o = 0 if cmd_wr_en_i = 0); writes still accepted. A host read handshake at cycle K frees a credit visible at K+1 (no same-cycle bypass).
- cmd_ready_o depends combinationally on cmd_wr_en_i and csr_req_ready_i; csr_rsp_ready_o depends combinationally on rd_ready_i. No other input-to-output paths.

## Test plan
- Reset: hold rst_i 2 cycles mid-traffic → all valids 0, err_o 0, busy_o 0, cmd_ready_o 1 on first post-reset cycle.
- Back-to-back writes: 4 writes addr 0..3, data 0xA0..0xA3, csr_req_ready_i always 1 → 4 consecutive CSR request cycles starting one cycle after first cmd, no rd_valid_o.
- Stall: write addr 5 data 0xDEADBEEF, csr_req_ready_i low 3 cycles → csr_* stable 3 cycles, cmd_ready_o 0, request completes cycle 4.
- Credit limit: MaxOutstanding=2, 3 reads, rd_ready_i held 0, responder returns 0x11, 0x22 → third read stalled; after host takes 0x11, third read issues next cycle; host sees 0x11, 0x22, then third data in order.
- Simultaneous: rsp handshake and host read handshake same cycle with buffer full → new data captured, no loss, rd_valid_o stays 1; rd_cnt and infl unchanged when inc/dec coincide.
- Error: csr_rsp_valid_i pulse with 0x55 while idle → err_o 1 next cycle, rd_valid_o stays 0, err_o stays 1 until rst_i.
